reg_write_arbiter: RTL and testbench

Round-robin write arbiter and owner of a shared 16-bit storage register. Up to N requesters compete each cycle to load the register. One winner per cycle commits its data, and the winner receives a one-cycle acknowledge. The block sits between the datapath units (ALU result, memory read-back, immediate load) and the shared A/D-style register. It replaces ad-hoc `load` muxing with fair, bounded-latency access.

---
 rtl/reg_write_arbiter.sv | 99 +++++++++
 tb/tb_reg_write_arbiter.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter that owns a shared storage register.
// Supports a per-requester burst lock with a bounded number of consecutive wins.
module reg_write_arbiter #(
   parameter  int N        = 4,
   parameter  int WIDTH    = 16,
   parameter  int MAX_HOLD = 4,
   localparam int LW       = $clog2(N),
   localparam int HW       = $clog2(MAX_HOLD + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic [N-1:0]         lock,
   input  logic [N*WIDTH-1:0]   wdata,
   input  logic                 clr,
   output logic [WIDTH-1:0]     out,
   output logic [N-1:0]         ack,
   output logic [LW-1:0]        owner,
   output logic                 busy
);

   logic [LW-1:0]    ptr;
   logic [HW-1:0]    hold_cnt;

   logic [N-1:0]     ptr_oh;
   logic [N-1:0]     others;
   logic             any_req;
   logic             lock_win;
   logic             rr_found;
   logic [LW-1:0]    rr_idx;
   logic [LW-1:0]    cand;
   logic [LW-1:0]    win_idx;
   logic [N-1:0]     win_oh;
   logic [HW-1:0]    hold_nxt;
   logic [WIDTH-1:0] win_data;

   always_comb begin
      ptr_oh      = '0;
      ptr_oh[ptr] = 1'b1;
      others      = req & ~ptr_oh;
      any_req     = |req;

      // The locked owner keeps winning until its budget runs out, unless nobody else wants the register.
      lock_win = req[ptr] && lock[ptr] &&
                 ((hold_cnt < HW'(MAX_HOLD)) || (others == '0));

      // Search starts just after the last winner and wraps back to it (k = N).
      rr_found = 1'b0;
      rr_idx   = ptr;
      cand     = ptr;
      for (int unsigned k = 1; k <= N; k++) begin
         cand = ptr + LW'(k);
         if (!rr_found && req[cand]) begin
            rr_found = 1'b1;
            rr_idx   = cand;
         end
      end

      win_idx         = lock_win ? ptr : rr_idx;
      win_oh          = '0;
      win_oh[win_idx] = 1'b1;
      win_data        = wdata[win_idx*WIDTH +: WIDTH];

      if (lock_win) begin
         hold_nxt = (hold_cnt == HW'(MAX_HOLD)) ? hold_cnt : hold_cnt + HW'(1);
      end else if (any_req) begin
         hold_nxt = HW'(1);
      end else begin
         hold_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out      <= '0;
         ack      <= '0;
         owner    <= '0;
         busy     <= 1'b0;
         ptr      <= LW'(N - 1);
         hold_cnt <= '0;
      end else begin
         busy <= any_req;
         if (clr) begin
            out <= '0;
            ack <= '0;
         end else if (any_req) begin
            out      <= win_data;
            ack      <= win_oh;
            ptr      <= win_idx;
            owner    <= win_idx;
            hold_cnt <= hold_nxt;
         end else begin
            ack      <= '0;
            hold_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: reference model feeds a scoreboard queue,
// each scenario task pops and compares after every edge.
module tb_reg_write_arbiter;

   localparam int N        = 4;
   localparam int WIDTH    = 16;
   localparam int MAX_HOLD = 4;
   localparam int LW       = $clog2(N);

   typedef struct packed {
      logic [WIDTH-1:0] out;
      logic [N-1:0]     ack;
      logic [LW-1:0]    owner;
      logic             busy;
   } obs_t;

   logic               clk;
   logic               rst_n;
   logic [N-1:0]       req;
   logic [N-1:0]       lock;
   logic [N*WIDTH-1:0] wdata;
   logic               clr;
   logic [WIDTH-1:0]   out;
   logic [N-1:0]       ack;
   logic [LW-1:0]      owner;
   logic               busy;

   obs_t expq[$];
   obs_t e;
   obs_t got;
   int   checks;
   int   errors;

   logic [WIDTH-1:0] m_out;
   logic [N-1:0]     m_ack;
   int               m_owner;
   logic             m_busy;
   int               m_ptr;
   int               m_hold;

   reg_write_arbiter #(.N(N), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .lock  (lock),
      .wdata (wdata),
      .clr   (clr),
      .out   (out),
      .ack   (ack),
      .owner (owner),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      m_out   = '0;
      m_ack   = '0;
      m_owner = 0;
      m_busy  = 1'b0;
      m_ptr   = N - 1;
      m_hold  = 0;
   endfunction

   function automatic obs_t pop_exp();
      obs_t r;
      r = 'x;
      if (expq.size() > 0) r = expq.pop_front();
      return r;
   endfunction

   function automatic obs_t sample();
      obs_t r;
      r.out   = out;
      r.ack   = ack;
      r.owner = owner;
      r.busy  = busy;
      return r;
   endfunction

   // Predict the register state after the coming edge from the inputs now applied.
   function automatic void model_edge();
      int   w;
      bit   lp;
      int   others;
      obs_t x;
      w = -1;
      lp = 0;
      others = 0;
      for (int i = 0; i < N; i++) if (req[i] && i != m_ptr) others++;
      if (req[m_ptr] && lock[m_ptr] && (m_hold < MAX_HOLD || others == 0)) begin
         w  = m_ptr;
         lp = 1;
      end else begin
         for (int k = 1; k <= N; k++)
            if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      m_busy = |req;
      if (clr) begin
         m_out = '0;
         m_ack = '0;
      end else if (w >= 0) begin
         m_out    = wdata[w*WIDTH +: WIDTH];
         m_ptr    = w;
         m_owner  = w;
         m_ack    = '0;
         m_ack[w] = 1'b1;
         m_hold   = lp ? ((m_hold < MAX_HOLD) ? m_hold + 1 : MAX_HOLD) : 1;
      end else begin
         m_ack  = '0;
         m_hold = 0;
      end
      x.out   = m_out;
      x.ack   = m_ack;
      x.owner = LW'(m_owner);
      x.busy  = m_busy;
      expq.push_back(x);
   endfunction

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int i, input logic [WIDTH-1:0] v);
      wdata[i*WIDTH +: WIDTH] = v;
   endtask

   task automatic do_reset();
      req   = '0;
      lock  = '0;
      clr   = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      expq.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      clr   = 1'b0;
      lock  = '0;
      wdata = '0;
      for (int c = 0; c < 3; c++) begin
         req = N'($urandom);
         @(posedge clk);
         #1;
         checks++;
         if ({out, ack, owner, busy} !== '0) begin
            errors++;
            $display("FAIL reset_hold got out=%h ack=%b owner=%0d busy=%b want all zero", out, ack, owner, busy);
         end
      end
      req   = '0;
      rst_n = 1'b1;
      model_reset();
      expq.delete();
      for (int c = 0; c < 5; c++) begin
         tick();
         e = pop_exp();
         got = sample();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL idle_sb got=%h exp=%h", got, e);
         end
         checks++;
         if (out !== 16'h0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_const got out=%h busy=%b want out=0000 busy=0", out, busy);
         end
      end
   endtask

   task automatic test_single();
      req = 4'b0100;
      set_data(2, 16'ha000);
      tick();
      e = pop_exp();
      got = sample();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL single_sb got=%h exp=%h", got, e);
      end
      checks++;
      if (out !== 16'ha000 || ack !== 4'b0100 || owner !== 2'd2) begin
         errors++;
         $display("FAIL single_win got out=%h ack=%b owner=%0d want a000 0100 2", out, ack, owner);
      end
      req = '0;
      tick();
      e = pop_exp();
      got = sample();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL single_drop_sb got=%h exp=%h", got, e);
      end
      checks++;
      if (out !== 16'ha000 || ack !== 4'b0000) begin
         errors++;
         $display("FAIL single_drop got out=%h ack=%b want a000 0000", out, ack);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < N; i++) set_data(i, WIDTH'(i * 16'h1111));
      req  = 4'b1111;
      lock = 4'b0000;
      for (int c = 0; c < 8; c++) begin
         tick();
         e = pop_exp();
         got = sample();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL rr_sb[%0d] got=%h exp=%h", c, got, e);
         end
         checks++;
         if (owner !== LW'(c % N) || out !== WIDTH'((c % N) * 16'h1111)) begin
            errors++;
            $display("FAIL rr_order[%0d] got owner=%0d out=%h want owner=%0d", c, owner, out, c % N);
         end
      end
   endtask

   task automatic test_lock_bound();
      int seq [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
      do_reset();
      set_data(0, 16'h00a0);
      set_data(1, 16'h0b01);
      req  = 4'b0011;
      lock = 4'b0001;
      for (int c = 0; c < 8; c++) begin
         tick();
         e = pop_exp();
         got = sample();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL lock_sb[%0d] got=%h exp=%h", c, got, e);
         end
         checks++;
         if (owner !== LW'(seq[c])) begin
            errors++;
            $display("FAIL lock_order[%0d] got owner=%0d want %0d", c, owner, seq[c]);
         end
      end
      req = 4'b0001;
      for (int c = 0; c < 10; c++) begin
         tick();
         e = pop_exp();
         got = sample();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL lock_solo_sb[%0d] got=%h exp=%h", c, got, e);
         end
         checks++;
         if (owner !== 2'd0 || ack !== 4'b0001) begin
            errors++;
            $display("FAIL lock_solo[%0d] got owner=%0d ack=%b want 0 0001", c, owner, ack);
         end
      end
      lock = '0;
   endtask

   task automatic test_clear();
      req = 4'b1000;
      set_data(3, 16'h0d00);
      tick();
      e = pop_exp();
      got = sample();
      checks++;
      if (got !== e || out !== 16'h0d00) begin
         errors++;
         $display("FAIL clr_setup got=%h exp=%h want out=0d00", got, e);
      end
      clr = 1'b1;
      req = 4'b0010;
      set_data(1, 16'h0bee);
      tick();
      e = pop_exp();
      got = sample();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL clr_sb got=%h exp=%h", got, e);
      end
      checks++;
      if (out !== 16'h0000 || ack !== 4'b0000 || busy !== 1'b1) begin
         errors++;
         $display("FAIL clr_prio got out=%h ack=%b busy=%b want 0000 0000 1", out, ack, busy);
      end
      clr = 1'b0;
      tick();
      e = pop_exp();
      got = sample();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL clr_after_sb got=%h exp=%h", got, e);
      end
      checks++;
      if (out !== 16'h0bee || ack !== 4'b0010 || owner !== 2'd1) begin
         errors++;
         $display("FAIL clr_after got out=%h ack=%b owner=%0d want 0bee 0010 1", out, ack, owner);
      end
      req = '0;
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 300; c++) begin
         req   = N'($urandom);
         lock  = N'($urandom & $urandom);
         clr   = ($urandom_range(0, 7) == 0);
         wdata = {$urandom, $urandom};
         tick();
         e = pop_exp();
         got = sample();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL random_sb[%0d] got=%h exp=%h", c, got, e);
         end
      end
      clr  = 1'b0;
      lock = '0;
      req  = '0;
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < N; i++) set_data(i, WIDTH'(16'h1000 + i * 16'h1111));
      req = 4'b1111;
      for (int c = 0; c < 3; c++) begin
         tick();
         e = pop_exp();
         got = sample();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL midrst_pre_sb[%0d] got=%h exp=%h", c, got, e);
         end
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out, ack, owner, busy} !== '0) begin
         errors++;
         $display("FAIL midrst_async got out=%h ack=%b owner=%0d busy=%b want all zero", out, ack, owner, busy);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      expq.delete();
      for (int c = 0; c < 2; c++) begin
         tick();
         e = pop_exp();
         got = sample();
         checks++;
         if (got !== e) begin
            errors++;
            $display("FAIL midrst_post_sb[%0d] got=%h exp=%h", c, got, e);
         end
         checks++;
         if (owner !== LW'(c) || ack !== N'(1 << c)) begin
            errors++;
            $display("FAIL midrst_order[%0d] got owner=%0d ack=%b want owner=%0d", c, owner, ack, c);
         end
      end
      req = '0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      req    = '0;
      lock   = '0;
      clr    = 1'b0;
      wdata  = '0;
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_lock_bound();
      test_clear();
      test_back_to_back();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
